depacketizer_vc: RTL
====================

// Module: depacketizer_vc
// PURPOSE
//  Receive-side NoC translator. Takes flits from a NoC output port, reassembles
//  packets of 1..PACKETIZER_WIDTH flits independently per virtual channel, and
//  presents each finished packet as one data word with a valid/ready handshake.
//  Sits between a router egress port and a module input port.
// PARAMETERS
//  ADDRESS_WIDTH     4   router address field width
//  VC_ADDRESS_WIDTH  1   VC field width; NUM_VC = 2**VC_ADDRESS_WIDTH
//  WIDTH_IN          36  NoC flit width
//  WIDTH_OUT         12  reassembled data width delivered to the module
//  PACKETIZER_WIDTH  1   maximum flits per packet (1..4)
// PORTS
//  clk        in   1               clock
//  rst        in   1               asynchronous reset, active-high
//  data_in    in   WIDTH_IN        flit from NoC
//  valid_in   in   1               flit valid
//  ready_out  out  NUM_VC          per-VC backpressure to NoC
//  data_out   out  WIDTH_OUT       reassembled payload
//  dst_out    out  ADDRESS_WIDTH   dest field of the packet's head flit
//  vc_out     out  VC_ADDRESS_WIDTH VC the packet arrived on
//  valid_out  out  1               packet valid
//  ready_in   in   1               module accepts packet
//  error_out  out  1               sticky protocol error (only with DEPKT_ERR_CHECK_EN)
// BEHAVIOUR
//  - Flit layout: [W-1]=valid, [W-2]=head, [W-3]=tail, next VC_ADDRESS_WIDTH =vc,
//    next ADDRESS_WIDTH =dest (head flit only, ignored on body), low P bits payload,
//    P = WIDTH_IN-3-VC_ADDRESS_WIDTH-ADDRESS_WIDTH.
//  - Flit accepted when valid_in & flit valid bit & ready_out[vc]. Per-VC slot:
//    flit counter (0..PACKETIZER_WIDTH), payload shift register, dest register, done.
//  - ready_out[v] = !done[v]; no combinational path from ready_in to ready_out.
//  - Head flit: counter<=1, capture dest, payload into shift reg. Body/tail: append
//    (first flit most significant). Tail (incl. head+tail single flit): done<=1.
//  - data_out = low WIDTH_OUT bits of the concatenation; zero-extend if short.
//  - Latency: tail accepted at edge N -> valid_out high from cycle after edge N.
//  - Output: combinational mux over done slots, round-robin grant. Grant locked while
//    valid_out & !ready_in (data_out/dst_out/vc_out stable). On valid_out&ready_in:
//    done[g]<=0, counter<=0, RR pointer <= g+1 mod NUM_VC.
//  - Per-VC throughput: one packet per (flits+1) cycles; VCs interleave freely.
//  - Reset: all counters/done/RR pointer 0; valid_out=0, ready_out=all 1s,
//    data_out/dst_out/vc_out=0, error_out=0. Partial packets discarded.
// CONFIGURATION
//  DEPKT_ERR_CHECK_EN defined: error_out sets and holds until rst on: body flit to
//  an idle slot (flit dropped), head flit to a mid-packet slot (restart from it),
//  flit count exceeding PACKETIZER_WIDTH without tail (force done). Not defined:
//  error_out port absent; illegal sequences are don't-care (head restarts slot,
//  body to idle slot appended, overflow beyond PACKETIZER_WIDTH wraps counter).
// STRUCTURE
//  Package depacketizer_vc_pkg: flit field offset/width functions of
//  (WIDTH_IN, ADDRESS_WIDTH, VC_ADDRESS_WIDTH), payload width P, head/tail bit
//  constants. Sub-module depacketizer_vc_slot: one reassembly slot, generate-
//  instantiated NUM_VC times; top holds RR arbiter, grant lock and output mux.
// TESTING
//  1. PW=1, head+tail flit vc0 dest=3 payload 0xABC, ready_in=1 -> next cycle
//     valid_out=1, data_out=0xABC, dst_out=3, vc_out=0; ready_out[0] low one cycle.
//  2. PW=2, WIDTH_OUT=2P: head(vc1,0x12) then tail(vc1,0x34) -> data_out={0x12,0x34}.
//  3. PW=2 interleave head vc0, head vc1, tail vc1, tail vc0 -> vc1 packet then vc0,
//     each correctly assembled, no cross-contamination.
//  4. Both VCs done, ready_in=0 for 5 cycles -> outputs stable, ready_out=2'b00;
//     ready_in=1 -> vc0 then vc1 delivered (RR), ready_out restored.
//  5. rst asserted after head flit of 2-flit packet -> all outputs reset value
//     immediately; post-reset tail-only flit not delivered as valid packet.
//  6. DEPKT_ERR_CHECK_EN: body flit to idle vc0 -> error_out=1 sticky, no valid_out.

Source files
------------

// File: rtl/depacketizer_vc_pkg.sv
// Shared definitions for the VC-aware depacketizer: flit field positions
// and payload width, all derived from the flit and address widths.
package depacketizer_vc_pkg;

  // Control bit offsets counted down from the flit MSB
  localparam int VALID_OFS = 1;
  localparam int HEAD_OFS  = 2;
  localparam int TAIL_OFS  = 3;

  function automatic int valid_bit(input int width_in);
    return width_in - VALID_OFS;
  endfunction

  function automatic int head_bit(input int width_in);
    return width_in - HEAD_OFS;
  endfunction

  function automatic int tail_bit(input int width_in);
    return width_in - TAIL_OFS;
  endfunction

  function automatic int vc_lsb(input int width_in, input int vc_width);
    return width_in - TAIL_OFS - vc_width;
  endfunction

  function automatic int dest_lsb(input int width_in, input int addr_width, input int vc_width);
    return width_in - TAIL_OFS - vc_width - addr_width;
  endfunction

  // Payload occupies everything below the dest field
  function automatic int payload_width(input int width_in, input int addr_width, input int vc_width);
    return dest_lsb(width_in, addr_width, vc_width);
  endfunction

endpackage

// File: rtl/depacketizer_vc_slot.sv
// One per-VC reassembly slot: flit counter, payload shift register, dest
// register and done flag. With DEPKT_ERR_CHECK_EN defined the slot also
// keeps a sticky protocol-error flag.
module depacketizer_vc_slot
  import depacketizer_vc_pkg::*;
#(
  parameter int P  = 28,
  parameter int AW = 4,
  parameter int PW = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            accept,
  input  logic            head,
  input  logic            tail,
  input  logic [AW-1:0]   dest_in,
  input  logic [P-1:0]    payload,
  input  logic            pop,
  output logic            done,
  output logic [PW*P-1:0] data,
  output logic [AW-1:0]   dest
`ifdef DEPKT_ERR_CHECK_EN
  ,
  output logic            err
`endif
);

  localparam int SW = PW * P;
  localparam int CW = (PW < 2) ? 1 : $clog2(PW + 1);

  logic [CW-1:0] cnt;
  logic [SW-1:0] appended;

  // First flit ends up most significant: shift left and insert new payload
  assign appended = (data << P) | SW'(payload);

  // Slot state: head restarts, body/tail append, pop frees the slot
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= {CW{1'b0}};
      done <= 1'b0;
      data <= {SW{1'b0}};
      dest <= {AW{1'b0}};
`ifdef DEPKT_ERR_CHECK_EN
      err  <= 1'b0;
`endif
    end else if (pop) begin
      cnt  <= {CW{1'b0}};
      done <= 1'b0;
    end else if (accept && head) begin
`ifdef DEPKT_ERR_CHECK_EN
      if (cnt != {CW{1'b0}}) begin
        err <= 1'b1;
      end
`endif
      cnt  <= CW'(1);
      dest <= dest_in;
      data <= SW'(payload);
      done <= tail;
    end else if (accept) begin
`ifdef DEPKT_ERR_CHECK_EN
      if (cnt == {CW{1'b0}}) begin
        // body flit with no open packet: drop it
        err <= 1'b1;
      end else if (cnt == CW'(PW)) begin
        // packet longer than a slot can hold: close what we have
        err  <= 1'b1;
        done <= 1'b1;
      end else begin
        cnt  <= cnt + CW'(1);
        data <= appended;
        done <= tail;
      end
`else
      cnt  <= cnt + CW'(1);
      data <= appended;
      // a stray tail with no open packet must never complete one
      done <= tail && (cnt != {CW{1'b0}});
`endif
    end
  end

endmodule

// File: rtl/depacketizer_vc.sv
// Receive-side NoC depacketizer with one reassembly slot per virtual channel.
// Finished packets are offered through a round-robin arbiter whose grant is
// held while the consumer stalls. Optional macro: DEPKT_ERR_CHECK_EN adds
// the sticky error_out port and protocol checking.
module depacketizer_vc
  import depacketizer_vc_pkg::*;
#(
  parameter int ADDRESS_WIDTH    = 4,
  parameter int VC_ADDRESS_WIDTH = 1,
  parameter int WIDTH_IN         = 36,
  parameter int WIDTH_OUT        = 12,
  parameter int PACKETIZER_WIDTH = 1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [WIDTH_IN-1:0]                 data_in,
  input  logic                                valid_in,
  output logic [(2**VC_ADDRESS_WIDTH)-1:0]    ready_out,
  output logic [WIDTH_OUT-1:0]                data_out,
  output logic [ADDRESS_WIDTH-1:0]            dst_out,
  output logic [VC_ADDRESS_WIDTH-1:0]         vc_out,
  output logic                                valid_out,
  input  logic                                ready_in
`ifdef DEPKT_ERR_CHECK_EN
  ,
  output logic                                error_out
`endif
);

  localparam int NUM_VC = 2**VC_ADDRESS_WIDTH;
  localparam int VW     = VC_ADDRESS_WIDTH;
  localparam int AW     = ADDRESS_WIDTH;
  localparam int P      = payload_width(WIDTH_IN, ADDRESS_WIDTH, VC_ADDRESS_WIDTH);
  localparam int SW     = PACKETIZER_WIDTH * P;
  localparam int EW     = (WIDTH_OUT > SW) ? WIDTH_OUT : SW;
  localparam int VALID_B = valid_bit(WIDTH_IN);
  localparam int HEAD_B  = head_bit(WIDTH_IN);
  localparam int TAIL_B  = tail_bit(WIDTH_IN);
  localparam int VC_L    = vc_lsb(WIDTH_IN, VC_ADDRESS_WIDTH);
  localparam int DEST_L  = dest_lsb(WIDTH_IN, ADDRESS_WIDTH, VC_ADDRESS_WIDTH);

  logic [VW-1:0]     flit_vc;
  logic              flit_ok;
  logic [NUM_VC-1:0] done;
  logic [NUM_VC-1:0] accept;
  logic [NUM_VC-1:0] pop;
  logic [SW-1:0]     slot_data [NUM_VC];
  logic [AW-1:0]     slot_dest [NUM_VC];
  logic [VW-1:0]     rr;
  logic [VW-1:0]     gnt;
  logic [VW-1:0]     gnt_held;
  logic              locked;
  logic [VW-1:0]     pick;
  logic [VW-1:0]     idx;
  logic              found;
  logic [EW-1:0]     ext;
`ifdef DEPKT_ERR_CHECK_EN
  logic [NUM_VC-1:0] slot_err;
  assign error_out = |slot_err;
`endif

  assign flit_vc   = data_in[VC_L +: VW];
  assign flit_ok   = valid_in & data_in[VALID_B];
  assign ready_out = ~done;

  for (genvar v = 0; v < NUM_VC; v++) begin : g_slot
    assign accept[v] = flit_ok & ready_out[v] & (flit_vc == VW'(v));
    assign pop[v]    = valid_out & ready_in & (gnt == VW'(v));

    depacketizer_vc_slot #(
      .P  (P),
      .AW (AW),
      .PW (PACKETIZER_WIDTH)
    ) u_slot (
      .clk     (clk),
      .rst     (rst),
      .accept  (accept[v]),
      .head    (data_in[HEAD_B]),
      .tail    (data_in[TAIL_B]),
      .dest_in (data_in[DEST_L +: AW]),
      .payload (data_in[P-1:0]),
      .pop     (pop[v]),
      .done    (done[v]),
      .data    (slot_data[v]),
      .dest    (slot_dest[v])
`ifdef DEPKT_ERR_CHECK_EN
      ,
      .err     (slot_err[v])
`endif
    );
  end

  // Round-robin pick starting at rr; a stalled grant stays put
  always_comb begin
    pick  = rr;
    found = 1'b0;
    idx   = rr;
    for (int i = 0; i < NUM_VC; i++) begin
      idx = rr + VW'(i);
      if (!found && done[idx]) begin
        found = 1'b1;
        pick  = idx;
      end else begin
        found = found;
      end
    end
    if (locked) begin
      gnt = gnt_held;
    end else begin
      gnt = pick;
    end
    valid_out = done[gnt];
  end

  // Output mux: zero when idle, payload zero-extended or truncated to WIDTH_OUT
  always_comb begin
    ext = EW'(slot_data[gnt]);
    if (valid_out) begin
      data_out = ext[WIDTH_OUT-1:0];
      dst_out  = slot_dest[gnt];
      vc_out   = gnt;
    end else begin
      data_out = {WIDTH_OUT{1'b0}};
      dst_out  = {AW{1'b0}};
      vc_out   = {VW{1'b0}};
    end
  end

  // Arbiter state: grant lock during stalls, pointer advance on delivery
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr       <= {VW{1'b0}};
      gnt_held <= {VW{1'b0}};
      locked   <= 1'b0;
    end else begin
      locked   <= valid_out & ~ready_in;
      gnt_held <= gnt;
      if (valid_out && ready_in) begin
        rr <= gnt + VW'(1);
      end
    end
  end

endmodule
